// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared FSM states, ALU selects and widths
// for the MAXNET winner-take-all controller.
package maxnet_pkg;

  localparam int DW = 32;
  localparam int NN = 4;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] SLT = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    SUB_T,
    SUB_N,
    CMP,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/maxnet_argmax.sv
// maxnet_argmax: nonzero count plus lowest-index argmax
// over the four shadow activations.
module maxnet_argmax
  import maxnet_pkg::*;
(
  input  logic [NN-1:0][DW-1:0] v_i,
  output logic [2:0]            cnt_o,
  output logic [1:0]            idx_o,
  output logic [DW-1:0]         val_o
);

  // strict '>' keeps the lowest index on ties
  always_comb begin
    cnt_o = '0;
    idx_o = '0;
    val_o = v_i[0];
    for (int i = 0; i < NN; i++) begin
      if (v_i[i] != '0) begin
        cnt_o = cnt_o + 3'd1;
      end
      if (v_i[i] > val_o) begin
        val_o = v_i[i];
        idx_o = 2'(i);
      end
    end
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: MAXNET competition sequencer driving an external ALU.
// Define MAXNET_EARLY_EXIT_EN to stop as soon as <=1 neuron survives.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int N_NEURON  = 4,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_NEURON*DW-1:0] act_in,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  output logic [3:0]             alu_sel,
  input  logic [DW-1:0]          alu_result,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             winner,
  output logic [DW-1:0]          winner_val,
  output logic [7:0]             iter_count,
  output logic                   timeout,
  output logic                   no_winner
);

  localparam logic [1:0] LAST     = 2'(N_NEURON - 1);
  localparam logic [7:0] ITER_MAX = 8'(MAX_ITER);

  state_e state_q, state_d;
  logic [N_NEURON-1:0][DW-1:0] a_q, a_d;
  logic [N_NEURON-1:0][DW-1:0] s_q, s_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] t_q, t_d;
  logic [DW-1:0] n_q, n_d;
  logic [DW-1:0] wval_q, wval_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    win_q, win_d;
  logic [7:0]    iter_q, iter_d;
  logic          to_q, to_d;
  logic          nw_q, nw_d;

  logic [2:0]    cnt;
  logic [1:0]    am_idx;
  logic [DW-1:0] am_val;
  logic [7:0]    iter_inc;
  logic          fin;

  maxnet_argmax u_argmax (
    .v_i   (s_q),
    .cnt_o (cnt),
    .idx_o (am_idx),
    .val_o (am_val)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    s_d      = s_q;
    acc_d    = acc_q;
    t_d      = t_q;
    n_d      = n_q;
    idx_d    = idx_q;
    iter_d   = iter_q;
    to_d     = to_q;
    nw_d     = nw_q;
    win_d    = win_q;
    wval_d   = wval_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_sel  = ADD;
    iter_inc = iter_q + 8'd1;
    fin      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = act_in;
          acc_d   = '0;
          iter_d  = '0;
          to_d    = 1'b0;
          nw_d    = 1'b0;
          idx_d   = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        alu_a = acc_q;
        alu_b = a_q[idx_q];
        acc_d = alu_result;
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST) begin
          state_d = SUB_T;
        end
      end
      SUB_T: begin
        alu_sel = SUB;
        alu_a   = acc_q;
        alu_b   = a_q[idx_q];
        t_d     = alu_result >> EPS_SHIFT;
        state_d = SUB_N;
      end
      SUB_N: begin
        alu_sel = SUB;
        alu_a   = a_q[idx_q];
        alu_b   = t_q;
        n_d     = alu_result;
        state_d = CMP;
      end
      CMP: begin
        alu_sel    = SLT;
        alu_a      = a_q[idx_q];
        alu_b      = t_q;
        s_d[idx_q] = alu_result[0] ? '0 : n_q;
        idx_d      = idx_q + 2'd1;
        state_d    = (idx_q == LAST) ? CHECK : SUB_T;
      end
      CHECK: begin
        a_d    = s_q;
        iter_d = iter_inc;
`ifdef MAXNET_EARLY_EXIT_EN
        if (cnt == 3'd1) begin
          fin = 1'b1;
        end else if (cnt == 3'd0) begin
          fin  = 1'b1;
          nw_d = 1'b1;
        end else if (iter_inc == ITER_MAX) begin
          fin  = 1'b1;
          to_d = 1'b1;
        end
`else
        if (iter_inc == ITER_MAX) begin
          fin  = 1'b1;
          nw_d = (cnt == 3'd0);
          to_d = (cnt > 3'd1);
        end
`endif
        if (fin) begin
          win_d   = am_idx;
          wval_d  = am_val;
          state_d = DONE;
        end else begin
          acc_d   = '0;
          state_d = SUM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      t_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      to_q    <= 1'b0;
      nw_q    <= 1'b0;
      win_q   <= '0;
      wval_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      to_q    <= to_d;
      nw_q    <= nw_d;
      win_q   <= win_d;
      wval_q  <= wval_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign winner     = win_q;
  assign winner_val = wval_q;
  assign iter_count = iter_q;
  assign timeout    = to_q;
  assign no_winner  = nw_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: vector table plus scoreboard for maxnet_ctrl,
// three instances with MAX_ITER 255 / 16 / 4 and a behavioural ALU.
module tb_maxnet_ctrl;
  import maxnet_pkg::*;

  localparam int ND    = 3;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start [ND];
  logic [127:0] act   [ND];
  logic [31:0]  aa    [ND];
  logic [31:0]  ab    [ND];
  logic [31:0]  ar    [ND];
  logic [31:0]  wv    [ND];
  logic [3:0]   asel  [ND];
  logic         bsy   [ND];
  logic         dn    [ND];
  logic         tmo   [ND];
  logic         nw    [ND];
  logic [1:0]   win   [ND];
  logic [7:0]   itc   [ND];

  function automatic logic [31:0] alu(input logic [3:0] s,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    case (s)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd5:    return {31'd0, ($signed(x) < $signed(y))};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    assign ar[k] = alu(asel[k], aa[k], ab[k]);
    maxnet_ctrl #(
      .MAX_ITER(k == 0 ? 255 : (k == 1 ? 16 : 4))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[k]),
      .act_in     (act[k]),
      .alu_a      (aa[k]),
      .alu_b      (ab[k]),
      .alu_sel    (asel[k]),
      .alu_result (ar[k]),
      .busy       (bsy[k]),
      .done       (dn[k]),
      .winner     (win[k]),
      .winner_val (wv[k]),
      .iter_count (itc[k]),
      .timeout    (tmo[k]),
      .no_winner  (nw[k])
    );
  end

  typedef struct {
    int           d;
    logic [127:0] act;
    logic [1:0]   win;
    logic [31:0]  val;
    logic [7:0]   it;
    logic         to;
    logic         nw;
    int           lat;
    bit           trace;
    bit           ign;
  } vec_t;

  typedef struct {
    int          c;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] b;
  } tr_t;

  vec_t vec [6];
  tr_t  tr  [$];
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [127:0] pk(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    int   cyc;
    logic [1:0] w;
    exp_q.push_back(v);
    @(negedge clk);
    act[v.d]   = v.act;
    start[v.d] = 1'b1;
    @(posedge clk);
    #1 start[v.d] = 1'b0;
    cyc = 0;
    while (!dn[v.d] && cyc < LIMIT) begin
      if (v.trace) begin
        foreach (tr[j]) begin
          if (tr[j].c == cyc) begin
            chk($sformatf("alu_sel@%0d", cyc), 32'(asel[v.d]), 32'(tr[j].s));
            chk($sformatf("alu_a@%0d", cyc), aa[v.d], tr[j].a);
            chk($sformatf("alu_b@%0d", cyc), ab[v.d], tr[j].b);
          end
        end
      end
      if (v.ign && cyc == 5) begin
        act[v.d]   = pk(7, 7, 7, 200);
        start[v.d] = 1'b1;
      end
      if (v.ign && cyc == 6) start[v.d] = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
    e = exp_q.pop_front();
    chk("done_seen", 32'(dn[v.d]), 32'd1);
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("winner", 32'(win[v.d]), 32'(e.win));
    chk("winner_val", wv[v.d], e.val);
    chk("iter_count", 32'(itc[v.d]), 32'(e.it));
    chk("timeout", 32'(tmo[v.d]), 32'(e.to));
    chk("no_winner", 32'(nw[v.d]), 32'(e.nw));
    w = win[v.d];
    @(posedge clk);
    #1;
    chk("busy_after", 32'(bsy[v.d]), 32'd0);
    chk("done_pulse", 32'(dn[v.d]), 32'd0);
    chk("winner_hold", 32'(win[v.d]), 32'(w));
    chk("iter_hold", 32'(itc[v.d]), 32'(e.it));
  endtask

  initial begin
    for (int k = 0; k < ND; k++) begin
      start[k] = 1'b0;
      act[k]   = '0;
    end

    tr.push_back('{0,  4'd0, 32'd0,   32'd80});
    tr.push_back('{1,  4'd0, 32'd80,  32'd40});
    tr.push_back('{4,  4'd1, 32'd144, 32'd80});
    tr.push_back('{5,  4'd1, 32'd80,  32'd8});
    tr.push_back('{6,  4'd5, 32'd80,  32'd8});
    tr.push_back('{7,  4'd1, 32'd144, 32'd40});
    tr.push_back('{16, 4'd0, 32'd0,   32'd0});
    tr.push_back('{17, 4'd0, 32'd0,   32'd72});
    tr.push_back('{18, 4'd0, 32'd72,  32'd27});
    tr.push_back('{19, 4'd0, 32'd99,  32'd0});

`ifdef MAXNET_EARLY_EXIT_EN
    vec[0] = '{0, pk(80, 40, 16, 8), 2'd0, 32'd66, 8'd5, 1'b0, 1'b0, 85, 1'b1, 1'b0};
    vec[1] = '{0, pk(0, 0, 50, 0), 2'd2, 32'd50, 8'd1, 1'b0, 1'b0, 17, 1'b0, 1'b0};
    vec[2] = '{1, pk(20, 20, 0, 0), 2'd0, 32'd7, 8'd16, 1'b1, 1'b0, 272, 1'b0, 1'b0};
    vec[3] = '{0, pk(0, 0, 0, 0), 2'd0, 32'd0, 8'd1, 1'b0, 1'b1, 17, 1'b0, 1'b0};
    vec[4] = '{2, pk(0, 0, 0, 100), 2'd3, 32'd100, 8'd1, 1'b0, 1'b0, 17, 1'b0, 1'b0};
    vec[5] = '{2, pk(0, 0, 50, 0), 2'd2, 32'd50, 8'd1, 1'b0, 1'b0, 17, 1'b0, 1'b1};
`else
    vec[0] = '{0, pk(80, 40, 16, 8), 2'd0, 32'd66, 8'd255, 1'b0, 1'b0, 4335, 1'b1, 1'b0};
    vec[1] = '{2, pk(0, 0, 50, 0), 2'd2, 32'd50, 8'd4, 1'b0, 1'b0, 68, 1'b0, 1'b0};
    vec[2] = '{1, pk(20, 20, 0, 0), 2'd0, 32'd7, 8'd16, 1'b1, 1'b0, 272, 1'b0, 1'b0};
    vec[3] = '{2, pk(0, 0, 0, 0), 2'd0, 32'd0, 8'd4, 1'b0, 1'b1, 68, 1'b0, 1'b0};
    vec[4] = '{2, pk(0, 0, 0, 100), 2'd3, 32'd100, 8'd4, 1'b0, 1'b0, 68, 1'b0, 1'b0};
    vec[5] = '{2, pk(0, 0, 50, 0), 2'd2, 32'd50, 8'd4, 1'b0, 1'b0, 68, 1'b0, 1'b1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_iter", 32'(itc[0]), 32'd0);
    chk("rst_wval", wv[0], 32'd0);
    chk("rst_alu_sel", 32'(asel[0]), 32'd0);
    chk("rst_alu_b", ab[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run(vec[i]);

    @(negedge clk);
    act[0]   = pk(80, 40, 16, 8);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    chk("midrst_done", 32'(dn[0]), 32'd0);
    chk("midrst_alu_sel", 32'(asel[0]), 32'd0);
    chk("midrst_alu_a", aa[0], 32'd0);
    chk("midrst_iter", 32'(itc[0]), 32'd0);
    chk("midrst_nw", 32'(nw[0]), 32'd0);
    chk("midrst_win2", 32'(win[2]), 32'd0);
    chk("midrst_wval2", wv[2], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(vec[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 The block SHALL have parameter N_NEURON, default 4, giving the neuron count (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter EPS_SHIFT, default 3, giving inhibition weight eps = 2^-EPS_SHIFT.
REQ-003 The block SHALL have parameter MAX_ITER, default 255, giving the iteration limit (1..255).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; one clock domain only.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a competition.
- act_in  in  128  four unsigned 32-bit activations; neuron i at [32i+31:32i].
- alu_a  out  32  ALU operand 1.
- alu_b  out  32  ALU operand 2.
- alu_sel  out  4  ALU op: ADD=0, SUB=1, SLT=5.
- alu_result  in  32  combinational ALU data_out, same cycle.
- busy  out  1  competition running.
- done  out  1  one-cycle completion pulse.
- winner  out  2  winning index.
- winner_val  out  32  winning final activation.
- iter_count  out  8  iterations executed.
- timeout  out  1  MAX_ITER reached without resolution.
- no_winner  out  1  all activations reached zero.

Function
REQ-005 The FSM SHALL have states IDLE, SUM, SUB_T, SUB_N, CMP, CHECK and DONE.
REQ-006 In IDLE with start=1, the block SHALL latch act_in into a[0..3], clear acc, iter_count, timeout and no_winner, and go to SUM.
REQ-007 SUM SHALL last 4 cycles, one per neuron, issuing ADD(acc, a[i]) and registering acc <= alu_result (32-bit wrap, no overflow detection).
REQ-008 Per neuron i, 3 cycles SHALL be used, with results written to shadow register s[i] and a[] unchanged within the iteration:
- SUB_T: SUB(acc, a[i]); register t = alu_result >> EPS_SHIFT (logical).
- SUB_N: SUB(a[i], t); register n.
- CMP: SLT(a[i], t); s[i] <= (alu_result[0] ? 0 : n).
REQ-009 CHECK SHALL take 1 cycle:
- commit a <= s.
- increment iter_count.
- count nonzero a.
- An iteration SHALL take exactly 17 cycles.
REQ-010 CHECK transitions SHALL be:
- count==1: go to DONE.
- count==0: set no_winner=1 and go to DONE.
- iter_count reaches MAX_ITER: set timeout=1 and go to DONE.
- otherwise: clear acc and go to SUM.
REQ-011 winner SHALL be the lowest index holding the maximum a[]; winner_val SHALL be that value; both SHALL be 0 when no_winner=1.
REQ-012 done SHALL be high for exactly the single DONE cycle; the FSM SHALL then return to IDLE, and winner, winner_val, iter_count, timeout and no_winner SHALL hold until the next start.
REQ-013 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy.
REQ-014 In IDLE, CHECK and DONE, alu_sel SHALL be ADD and alu_a and alu_b SHALL be 0.

Reset
REQ-015 When rst_n=0, the block SHALL immediately force IDLE and clear a[], s[], acc, busy, done, winner, winner_val, iter_count, timeout and no_winner, including mid-iteration; a partial iteration SHALL be discarded.

Configuration
REQ-016 With MAXNET_EARLY_EXIT_EN defined, CHECK SHALL exit on count<=1 as in REQ-010.
REQ-017 Without MAXNET_EARLY_EXIT_EN, the block SHALL always run MAX_ITER iterations:
- no_winner SHALL be set only if the final count is 0.
- timeout SHALL be set only if the final count is >1.

Structure
REQ-018 Package maxnet_pkg SHALL hold the FSM state enum, the ALU select constants ADD/SUB/SLT and the data width (32).
REQ-019 Nonzero counting and argmax SHALL live in combinational sub-module maxnet_argmax.

Verification
REQ-020 The bench SHALL cover these scenarios (EARLY_EXIT_EN defined unless noted):
- act {80,40,16,8} -> after iteration 1 a={72,27,0,0}; at finish winner=0, winner_val=66, iter_count=5; done rises 85 cycles after the edge that samples start.
- act {0,0,50,0} -> winner=2, winner_val=50, iter_count=1, done rises after 17 cycles.
- act {20,20,0,0}, MAX_ITER=16 -> timeout=1, iter_count=16, winner=0, winner_val=7.
- act {0,0,0,0} -> no_winner=1, winner=0, winner_val=0, iter_count=1.
- rst_n low during cycle 10 of a run -> busy=0 and state IDLE immediately; a start pulse while busy is ignored.
- Macro undefined, act {0,0,50,0}, MAX_ITER=4 -> iter_count=4, winner=2, winner_val=50, timeout=0.
